// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Frame timing is derived from the transmitter configuration.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLock,
      StGap
   } state_e;

   localparam int unsigned NreqDflt   = 4;
   localparam int unsigned GrantWDflt = $clog2(NreqDflt);

   // Cycles from one load strobe to the earliest safe next load strobe.
   function automatic int unsigned frame_cycles(input int unsigned fclk, input int unsigned bauds,
                                                input int unsigned wdata, input int unsigned wstop);
      return (fclk / bauds + 1) * (1 + wdata + wstop) + 2;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i scanning from ptr_i upward,
// wrapping modulo N.
module rr_pick #(
   parameter int unsigned  N  = 4,
   localparam int unsigned Iw = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  valid_i,
   input  logic [Iw-1:0] ptr_i,
   output logic [Iw-1:0] winner_o,
   output logic          any_valid_o
);

   logic [Iw:0] sum;

   // Walk the scan order backwards so the earliest candidate is the last to win.
   always_comb begin
      winner_o    = '0;
      any_valid_o = |valid_i;
      sum         = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         sum = {1'b0, ptr_i} + (Iw + 1)'(k);
         if (sum >= (Iw + 1)'(N)) begin
            sum = sum - (Iw + 1)'(N);
         end
         if (valid_i[sum[Iw-1:0]]) begin
            winner_o = sum[Iw-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked sharing of one UART transmitter among Nreq byte streams,
// with frame pacing by a gap counter since the transmitter exposes no busy flag.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned  Nreq  = 4,
   parameter int unsigned  Wdata = 8,
   parameter int unsigned  Wstop = 1,
   parameter int unsigned  Bauds = 115200,
   parameter int unsigned  Fclk  = 12000000,
   parameter int unsigned  Tidle = 4096,
   localparam int unsigned Gw    = $clog2(Nreq)
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [Nreq*Wdata-1:0] REQ_DIN,
   input  logic [Nreq-1:0]       REQ_VALID,
   input  logic [Nreq-1:0]       REQ_LAST,
   output logic [Nreq-1:0]       REQ_READY,
   output logic [Wdata-1:0]      TX_DIN,
   output logic                  TX_OE,
   output logic                  TX_RST,
   output logic [Gw-1:0]         GRANT,
   output logic                  BUSY
);

   localparam int unsigned Nbusy = frame_cycles(Fclk, Bauds, Wdata, Wstop);
   localparam int unsigned GapW  = $clog2(Nbusy);
   localparam int unsigned IdleW = (Tidle > 0) ? $clog2(Tidle + 1) : 1;
   localparam logic [GapW-1:0]  GapLoad  = GapW'(Nbusy - 2);
   localparam logic [IdleW-1:0] IdleLast = IdleW'(Tidle - 1);

   state_e            state_q, state_d;
   logic [Gw-1:0]     ptr_q, ptr_d;
   logic [Gw-1:0]     grant_q, grant_d;
   logic [GapW-1:0]   gap_q, gap_d;
   logic [IdleW-1:0]  idle_q, idle_d;
   logic              last_q, last_d;
   logic [Wdata-1:0]  tx_din_q, tx_din_d;
   logic              tx_oe_q, tx_oe_d;
   logic              tx_rst_q;
   logic [Gw-1:0]     pick;
   logic              any_valid;
   logic [Gw-1:0]     next_ptr;

   rr_pick #(
      .N(Nreq)
   ) u_pick (
      .valid_i    (REQ_VALID),
      .ptr_i      (ptr_q),
      .winner_o   (pick),
      .any_valid_o(any_valid)
   );

   assign next_ptr = (grant_q == Gw'(Nreq - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      gap_d    = gap_q;
      idle_d   = idle_q;
      last_d   = last_q;
      tx_din_d = tx_din_q;
      tx_oe_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               grant_d = pick;
               idle_d  = '0;
               state_d = StLock;
            end
         end
         StLock: begin
            if (REQ_VALID[grant_q]) begin
               tx_din_d = REQ_DIN[grant_q*Wdata +: Wdata];
               tx_oe_d  = 1'b1;
               last_d   = REQ_LAST[grant_q];
               gap_d    = GapLoad;
               state_d  = StGap;
            end else if ((Tidle != 0) && (idle_q == IdleLast)) begin
               // Stalled owner loses the lock; its message is truncated.
               ptr_d   = next_ptr;
               state_d = StIdle;
            end else if (idle_q != '1) begin
               idle_d = idle_q + 1'b1;
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               if (last_q) begin
                  ptr_d   = next_ptr;
                  state_d = StIdle;
               end else begin
                  idle_d  = '0;
                  state_d = StLock;
               end
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         grant_q  <= '0;
         gap_q    <= '0;
         idle_q   <= '0;
         last_q   <= 1'b0;
         tx_din_q <= '0;
         tx_oe_q  <= 1'b0;
         tx_rst_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         gap_q    <= gap_d;
         idle_q   <= idle_d;
         last_q   <= last_d;
         tx_din_q <= tx_din_d;
         tx_oe_q  <= tx_oe_d;
         tx_rst_q <= 1'b0;
      end
   end

   always_comb begin
      REQ_READY = '0;
      if (state_q == StLock) begin
         REQ_READY[grant_q] = 1'b1;
      end
   end

   assign TX_DIN = tx_din_q;
   assign TX_OE  = tx_oe_q;
   assign TX_RST = tx_rst_q;
   assign GRANT  = grant_q;
   assign BUSY   = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with Fclk=16, Bauds=4 (frame spacing 52), Nreq=4, Tidle=100.
module tb_uart_tx_arbiter;

   logic        CLK = 1'b0;
   logic        RSTN;
   logic [31:0] REQ_DIN;
   logic [3:0]  REQ_VALID;
   logic [3:0]  REQ_LAST;
   logic [3:0]  REQ_READY;
   logic [7:0]  TX_DIN;
   logic        TX_OE;
   logic        TX_RST;
   logic [1:0]  GRANT;
   logic        BUSY;

   always #5 CLK = ~CLK;

   uart_tx_arbiter #(
      .Nreq (4),
      .Wdata(8),
      .Wstop(1),
      .Bauds(4),
      .Fclk (16),
      .Tidle(100)
   ) dut (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .REQ_DIN  (REQ_DIN),
      .REQ_VALID(REQ_VALID),
      .REQ_LAST (REQ_LAST),
      .REQ_READY(REQ_READY),
      .TX_DIN   (TX_DIN),
      .TX_OE    (TX_OE),
      .TX_RST   (TX_RST),
      .GRANT    (GRANT),
      .BUSY     (BUSY)
   );

   typedef struct {
      int unsigned cyc;
      logic [7:0]  din;
      logic [1:0]  grant;
   } oe_t;

   typedef struct {
      int         req;
      logic [7:0] din;
      logic       last;
      int         exp_grant;
      int         exp_space;
   } vec_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   oe_t         oe_q[$];
   logic [8:0]  rq[4][$];
   logic [3:0]  pend;
   vec_t        vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
      #2;
   endtask

   task automatic wait_oe(input int n, input int budget, input string name);
      int k = 0;
      while (oe_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(oe_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k = 0;
      while (BUSY && k < budget) begin
         tick();
         k++;
      end
      check(name, 32'(BUSY), 32'd0);
   endtask

   task automatic check_oe(input string name, input int k, input int g, input int d, input int sp);
      if (k >= oe_q.size()) begin
         check({name, "_present"}, 32'd0, 32'd1);
      end else begin
         check({name, "_grant"}, 32'(oe_q[k].grant), 32'(g));
         check({name, "_din"}, 32'(oe_q[k].din), 32'(d));
         if (sp > 0 && k > 0) begin
            check({name, "_space"}, oe_q[k].cyc - oe_q[k-1].cyc, 32'(sp));
         end
      end
   endtask

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   // Requester model: presents queue heads, pops a byte once it was seen accepted.
   initial begin
      REQ_VALID = '0;
      REQ_LAST  = '0;
      REQ_DIN   = '0;
      pend      = '0;
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 4; i++) begin
            if (pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
               REQ_VALID[i]     = 1'b1;
               REQ_LAST[i]      = rq[i][0][8];
               REQ_DIN[i*8 +: 8] = rq[i][0][7:0];
            end else begin
               REQ_VALID[i]     = 1'b0;
               REQ_LAST[i]      = 1'b0;
               REQ_DIN[i*8 +: 8] = 8'h00;
            end
         end
         #3;
         for (int i = 0; i < 4; i++) pend[i] = RSTN && REQ_VALID[i] && REQ_READY[i];
      end
   end

   // Load-strobe monitor.
   initial begin
      logic prev_oe = 1'b0;
      forever begin
         @(negedge CLK);
         if (TX_OE === 1'b1) begin
            check("oe_one_cycle", 32'(prev_oe), 32'd0);
            check("ready_in_gap", 32'(REQ_READY), 32'd0);
            check("busy_in_gap", 32'(BUSY), 32'd1);
            oe_q.push_back('{cyc, TX_DIN, GRANT});
         end
         prev_oe = (TX_OE === 1'b1);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic        seen;
      int          k;
      int unsigned c_r;

      vecs[0] = '{0, 8'h10, 1'b1, 0, 0};
      vecs[1] = '{1, 8'h11, 1'b1, 1, 53};
      vecs[2] = '{2, 8'h12, 1'b1, 2, 53};
      vecs[3] = '{3, 8'h13, 1'b1, 3, 53};
      vecs[4] = '{0, 8'h14, 1'b1, 0, 53};

      // Reset and idle
      RSTN = 1'b0;
      tick(); tick(); tick();
      check("rst_tx_rst", 32'(TX_RST), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_oe", 32'(TX_OE), 32'd0);
      check("rst_ready", 32'(REQ_READY), 32'd0);
      check("rst_grant", 32'(GRANT), 32'd0);
      check("rst_din", 32'(TX_DIN), 32'd0);
      RSTN = 1'b1;
      tick();
      check("rst_release_tx_rst", 32'(TX_RST), 32'd0);
      repeat (5) tick();
      check("idle_busy", 32'(BUSY), 32'd0);
      check("idle_no_oe", 32'(oe_q.size()), 32'd0);

      // Two-byte message from requester 1
      oe_q.delete();
      rq[1].push_back({1'b0, 8'hA5});
      rq[1].push_back({1'b1, 8'h3C});
      wait_oe(2, 200, "msg_oe_count");
      check_oe("msg_b0", 0, 1, 'hA5, 0);
      check_oe("msg_b1", 1, 1, 'h3C, 52);
      wait_idle(100, "msg_idle");
      check("din_hold", 32'(TX_DIN), 32'h3C);

      // Pointer now 2: requester 2 beats requester 0
      oe_q.delete();
      rq[0].push_back({1'b1, 8'h01});
      rq[2].push_back({1'b1, 8'h02});
      wait_oe(2, 200, "ptr_oe_count");
      check_oe("ptr_first", 0, 2, 'h02, 0);
      check_oe("ptr_second", 1, 0, 'h01, 53);
      wait_idle(100, "ptr_idle");

      // Round-robin from pointer 0
      RSTN = 1'b0;
      tick(); tick();
      RSTN = 1'b1;
      tick();
      oe_q.delete();
      for (int i = 0; i < 5; i++) rq[vecs[i].req].push_back({vecs[i].last, vecs[i].din});
      wait_oe(5, 400, "rr_oe_count");
      for (int i = 0; i < 5; i++) begin
         check_oe($sformatf("rr_%0d", i), i, vecs[i].exp_grant, int'(vecs[i].din),
                  vecs[i].exp_space);
      end
      wait_idle(100, "rr_idle");

      // Lock hold: requester 2 waits out requester 0's 3-byte message
      oe_q.delete();
      rq[0].push_back({1'b0, 8'h21});
      rq[0].push_back({1'b0, 8'h22});
      rq[0].push_back({1'b1, 8'h23});
      wait_oe(1, 20, "lock_start");
      rq[2].push_back({1'b1, 8'h40});
      seen = 1'b0;
      k = 0;
      while (oe_q.size() < 3 && k < 300) begin
         tick();
         if (REQ_READY[2]) seen = 1'b1;
         k++;
      end
      check("lock_hold_ready2", 32'(seen), 32'd0);
      wait_oe(4, 200, "lock_oe_count");
      check_oe("lock_b0", 0, 0, 'h21, 0);
      check_oe("lock_b1", 1, 0, 'h22, 52);
      check_oe("lock_b2", 2, 0, 'h23, 52);
      check_oe("lock_next", 3, 2, 'h40, 53);
      wait_idle(100, "lock_idle");

      // Stall timeout on requester 3, release scans from 0
      oe_q.delete();
      rq[3].push_back({1'b0, 8'h77});
      wait_oe(1, 20, "stall_oe");
      rq[0].push_back({1'b1, 8'h30});
      rq[2].push_back({1'b1, 8'h32});
      repeat (100) tick();
      check("stall_grant", 32'(GRANT), 32'd3);
      check("stall_ready", 32'(REQ_READY), 32'h8);
      check("stall_busy", 32'(BUSY), 32'd1);
      wait_oe(3, 300, "stall_oe_count");
      check_oe("stall_b0", 0, 3, 'h77, 0);
      check_oe("stall_next", 1, 0, 'h30, 153);
      check_oe("stall_after", 2, 2, 'h32, 53);
      wait_idle(100, "stall_idle");

      // Reset mid-frame
      oe_q.delete();
      rq[1].push_back({1'b0, 8'h61});
      rq[1].push_back({1'b1, 8'h62});
      wait_oe(1, 20, "mid_oe");
      repeat (20) tick();
      RSTN = 1'b0;
      tick();
      check("mid_tx_rst", 32'(TX_RST), 32'd1);
      check("mid_busy", 32'(BUSY), 32'd0);
      check("mid_ready", 32'(REQ_READY), 32'd0);
      check("mid_oe", 32'(TX_OE), 32'd0);
      check("mid_grant", 32'(GRANT), 32'd0);
      check("mid_din", 32'(TX_DIN), 32'd0);
      tick();
      RSTN = 1'b1;
      tick();
      check("post_tx_rst", 32'(TX_RST), 32'd0);
      check("post_no_oe", 32'(oe_q.size()), 32'd1);
      c_r = cyc;
      wait_oe(2, 20, "post_oe");
      check_oe("post_first", 1, 1, 'h62, 0);
      if (oe_q.size() >= 2) check("post_latency", oe_q[1].cyc - c_r, 32'd1);
      wait_idle(100, "post_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
